// File: rtl/ghr_pkg.sv
// ---------------------------------------------------------------------------
// ghr_pkg
// Shared types and defaults for the speculative global-history controller.
//   GHR_W          default history width
//   CKPT_DEPTH_DEF default number of in-flight checkpoints
//   ckpt_t         one checkpoint: history before the branch plus its prediction
// ---------------------------------------------------------------------------
package ghr_pkg;

    localparam int GHR_W          = 10;
    localparam int CKPT_DEPTH_DEF = 4;

    typedef struct packed {
        logic [GHR_W-1:0] ghr;
        logic             pred;
    } ckpt_t;

endpackage

// File: rtl/ghr_ckpt_fifo.sv
// ---------------------------------------------------------------------------
// ghr_ckpt_fifo
// In-order checkpoint FIFO with push, pop and clear (clear beats push).
// Ports:
//   clk      clock
//   rst      synchronous active-low reset (pointers and count only)
//   push_i   write wdata_i at the tail
//   pop_i    drop the head entry
//   clear_i  empty the FIFO
//   wdata_i  entry to push
//   head_o   oldest entry
//   count_o  occupied entries, 0..DEPTH
//   full_o   count_o == DEPTH
// ---------------------------------------------------------------------------
module ghr_ckpt_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst && push_i && !clear_i) mem_q[wr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/ghr_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// ghr_checkpoint_ctrl
// Speculative global-history controller for the YAGS predictor front end.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   fetch_branch    branch predicted in IF this cycle
//   fetch_pred      predicted direction (1 = taken)
//   fetch_ready     a checkpoint slot is free
//   resolve_valid   oldest in-flight branch resolves this cycle
//   resolve_taken   actual direction
//   flush           non-branch pipeline flush
//   spec_ghr        speculative history
//   commit_ghr      history of resolved branches
//   mispredict      one-cycle pulse after a disagreeing resolve
//   ckpt_count      occupied checkpoint entries
//   resolve_err     sticky: resolve seen with no checkpoint outstanding
// ---------------------------------------------------------------------------
module ghr_checkpoint_ctrl
    import ghr_pkg::*;
#(
    parameter int GHR_size   = GHR_W,
    parameter int CKPT_DEPTH = CKPT_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_branch,
    input  logic                          fetch_pred,
    output logic                          fetch_ready,
    input  logic                          resolve_valid,
    input  logic                          resolve_taken,
    input  logic                          flush,
    output logic [GHR_size-1:0]           spec_ghr,
    output logic [GHR_size-1:0]           commit_ghr,
    output logic                          mispredict,
    output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
    output logic                          resolve_err
);

    localparam int EW = GHR_size + 1;

    logic [GHR_size-1:0] spec_q, spec_d, commit_q, commit_d;
    logic                mis_q, mis_d, err_q, err_d;

    logic [EW-1:0]       head;
    logic [GHR_size-1:0] head_ghr;
    logic                head_pred;
    logic                fifo_full;
    logic                accept, resolve, mis_res;
    logic                f_push, f_pop, f_clear;

    assign head_ghr  = head[EW-1:1];
    assign head_pred = head[0];

    assign accept  = fetch_branch & ~fifo_full;
    assign resolve = resolve_valid & (ckpt_count != '0);
    assign mis_res = resolve & (resolve_taken != head_pred);

    // Priority: flush > mispredicting resolve > normal push/pop.
    always_comb begin
        spec_d   = spec_q;
        commit_d = commit_q;
        mis_d    = 1'b0;
        err_d    = err_q | (resolve_valid & (ckpt_count == '0));
        f_push   = 1'b0;
        f_pop    = 1'b0;
        f_clear  = 1'b0;

        // Commit history tracks every real resolve, even under flush.
        if (resolve) commit_d = {commit_q[GHR_size-2:0], resolve_taken};

        if (flush) begin
            spec_d  = commit_q;
            f_clear = 1'b1;
        end else if (mis_res) begin
            // Younger checkpoints are wrong-path; rebuild from the head.
            spec_d  = {head_ghr[GHR_size-2:0], resolve_taken};
            f_clear = 1'b1;
            mis_d   = 1'b1;
        end else begin
            f_pop  = resolve;
            f_push = accept;
            if (accept) spec_d = {spec_q[GHR_size-2:0], fetch_pred};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spec_q   <= '0;
            commit_q <= '0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            spec_q   <= spec_d;
            commit_q <= commit_d;
            mis_q    <= mis_d;
            err_q    <= err_d;
        end
    end

    ghr_ckpt_fifo #(
        .W     (EW),
        .DEPTH (CKPT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (f_push),
        .pop_i   (f_pop),
        .clear_i (f_clear),
        .wdata_i ({spec_q, fetch_pred}),
        .head_o  (head),
        .count_o (ckpt_count),
        .full_o  (fifo_full)
    );

    assign fetch_ready = ~fifo_full;
    assign spec_ghr    = spec_q;
    assign commit_ghr  = commit_q;
    assign mispredict  = mis_q;
    assign resolve_err = err_q;

endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
module tb_ghr_checkpoint_ctrl;

    localparam int GW = 10;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_branch, fetch_pred, resolve_valid, resolve_taken, flush;
    logic          fetch_ready, mispredict, resolve_err;
    logic [GW-1:0] spec_ghr, commit_ghr;
    logic [2:0]    ckpt_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ghr_checkpoint_ctrl #(.GHR_size(GW), .CKPT_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_branch  (fetch_branch),
        .fetch_pred    (fetch_pred),
        .fetch_ready   (fetch_ready),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .flush         (flush),
        .spec_ghr      (spec_ghr),
        .commit_ghr    (commit_ghr),
        .mispredict    (mispredict),
        .ckpt_count    (ckpt_count),
        .resolve_err   (resolve_err)
    );

    // Reference model: history values plus a queue of in-flight checkpoints.
    typedef struct packed {
        bit [GW-1:0] g;
        bit          p;
    } ent_t;

    bit [GW-1:0] m_spec, m_commit;
    bit          m_mis, m_err;
    ent_t        m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("spec_ghr",    32'(spec_ghr),    32'(m_spec));
        chk("commit_ghr",  32'(commit_ghr),  32'(m_commit));
        chk("ckpt_count",  32'(ckpt_count),  32'(m_q.size()));
        chk("mispredict",  32'(mispredict),  32'(m_mis));
        chk("resolve_err", 32'(resolve_err), 32'(m_err));
        chk("fetch_ready", 32'(fetch_ready), 32'(m_q.size() != D));
    endtask

    task automatic model_edge(input bit fb, input bit fp, input bit rv, input bit rt, input bit fl);
        bit          res, mis, acc;
        ent_t        h;
        bit [GW-1:0] spec_n, commit_n;
        acc      = fb && (m_q.size() != D);
        res      = rv && (m_q.size() > 0);
        mis      = 1'b0;
        spec_n   = m_spec;
        commit_n = m_commit;
        if (rv && m_q.size() == 0) m_err = 1'b1;
        if (res) begin
            h        = m_q[0];
            commit_n = {m_commit[GW-2:0], rt};
            mis      = (rt != h.p);
        end
        m_mis = 1'b0;
        if (fl) begin
            spec_n = m_commit;
            m_q.delete();
        end else if (mis) begin
            spec_n = {h.g[GW-2:0], rt};
            m_q.delete();
            m_mis = 1'b1;
        end else begin
            if (res) void'(m_q.pop_front());
            if (acc) begin
                m_q.push_back('{g: m_spec, p: fp});
                spec_n = {m_spec[GW-2:0], fp};
            end
        end
        m_spec   = spec_n;
        m_commit = commit_n;
    endtask

    task automatic step(input bit fb, input bit fp, input bit rv, input bit rt, input bit fl);
        fetch_branch  = fb;
        fetch_pred    = fp;
        resolve_valid = rv;
        resolve_taken = rt;
        flush         = fl;
        @(posedge clk);
        model_edge(fb, fp, rv, rt, fl);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        fetch_branch  = 1'b0;
        fetch_pred    = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
        @(posedge clk);
        m_spec   = '0;
        m_commit = '0;
        m_mis    = 1'b0;
        m_err    = 1'b0;
        m_q.delete();
        #1;
        rst = 1'b1;
        check_all();
    endtask

    initial begin
        // Test 1: three accepts from zero history.
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("t1_spec",   32'(spec_ghr),   32'h005);
        chk("t1_count",  32'(ckpt_count), 32'd3);
        chk("t1_commit", 32'(commit_ghr), 32'd0);

        // Test 2: fill to four, fifth fetch ignored.
        step(1, 1, 0, 0, 0);
        chk("t2_ready", 32'(fetch_ready), 32'd0);
        step(1, 1, 0, 0, 0);
        chk("t2_spec",  32'(spec_ghr),   32'h00B);
        chk("t2_count", 32'(ckpt_count), 32'd4);

        // Test 3: preds 1,1 then mispredicting resolve.
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("t3_spec",   32'(spec_ghr),   32'd0);
        chk("t3_count",  32'(ckpt_count), 32'd0);
        chk("t3_mis",    32'(mispredict), 32'd1);
        chk("t3_commit", 32'(commit_ghr), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("t3_mis_pulse", 32'(mispredict), 32'd0);

        // Test 4: flush together with a correct resolve.
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("t4_pre_commit", 32'(commit_ghr), 32'h003);
        step(0, 0, 1, 1, 1);
        chk("t4_spec",   32'(spec_ghr),   32'h003);
        chk("t4_commit", 32'(commit_ghr), 32'h007);
        chk("t4_count",  32'(ckpt_count), 32'd0);

        // Test 5: correct resolve plus accept; then expose the new head.
        do_reset();
        step(1, 1, 0, 0, 0);           // entry0 ghr=0   pred=1
        step(1, 0, 0, 0, 0);           // entry1 ghr=1   pred=0
        step(1, 1, 1, 1, 0);           // pop entry0, push entry2 ghr=2
        chk("t5_count", 32'(ckpt_count), 32'd2);
        step(0, 0, 1, 1, 0);           // head is entry1 (pred 0): mispredict
        chk("t5_spec", 32'(spec_ghr),   32'h003);
        chk("t5_mis",  32'(mispredict), 32'd1);

        // Test 6: resolve on empty FIFO, sticky error, then reset.
        do_reset();
        step(0, 0, 1, 1, 0);
        chk("t6_err", 32'(resolve_err), 32'd1);
        step(1, 1, 0, 0, 0);
        chk("t6_err_sticky", 32'(resolve_err), 32'd1);
        do_reset();
        chk("t6_rst_err",  32'(resolve_err), 32'd0);
        chk("t6_rst_spec", 32'(spec_ghr),    32'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 99) < 60),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 99) < 40),
                     1'($urandom_range(0, 99) < 70),
                     1'($urandom_range(0, 99) < 4));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
